fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Sequencer for the instruction-fetch path. It owns the program counter, issues word requests to a multi-cycle instruction memory over a req/ack handshake, and presents each fetched instruction to decode over a valid/ready handshake. It accepts branch/jump redirects at any time, discards stale in-flight data, and halts on an illegal fetch address. It sits between the next-PC logic of the core and the instruction memory.

## Interface
- RESET_PC, 32'h0000_3000, first fetch address after reset
- IM_WORDS, 1024, instruction memory depth in words; legal fetch window is [RESET_PC, RESET_PC + 4*IM_WORDS)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- redirect  in  1  one-cycle pulse: change flow to redirect_pc
- redirect_pc  in  32  redirect target byte address
- im_req  out  1  fetch request to instruction memory
- im_addr  out  32  byte address of the request; equals current pc
- im_ack  in  1  memory returns im_rdata this cycle
- im_rdata  in  32  instruction word
- instr_valid  out  1  instr/pc hold a fetched instruction
- instr  out  32  fetched instruction
- pc  out  32  address of the instruction being fetched or presented
- instr_ready  in  1  decode consumes instr this cycle
- fetch_err  out  1  sticky illegal-address flag

## Operation
- States: START, REQ, VALID, DROP, HALT. Internal pc register, pending-target register tgt.
- Reset (reset low, asynchronous): state=START, pc=RESET_PC, tgt=0, instr=0. Outputs: im_req=0, instr_valid=0, fetch_err=0, im_addr=pc=RESET_PC.
- START: im_req=0. Next edge goes to REQ.
- REQ: im_req=1, im_addr=pc.
  - im_ack and no redirect: instr<=im_rdata, go to VALID.
  - redirect without im_ack: tgt<=redirect_pc, go to DROP.
  - redirect with im_ack: drop im_rdata, pc<=redirect_pc, stay in REQ.
- DROP: im_req=1 with the old im_addr until im_ack. A later redirect overwrites tgt. On im_ack: drop the data, pc<=tgt (or redirect_pc if redirect is in the same cycle), go to REQ.
- VALID: instr_valid=1.
  - instr_ready and no redirect: pc<=pc+4, go to REQ.
  - redirect (with or without instr_ready): the instruction is discarded, pc<=redirect_pc, go to REQ. Redirect has priority over ready.
- Handshake rule: once im_req is asserted, im_req and im_addr stay stable until the im_ack cycle, inclusive. im_req is never withdrawn without an ack.
- Legality check applies to every new pc value (pc+4 and redirect targets) at the edge it would be loaded. The address is illegal if addr[1:0]!=0 or it is outside the fetch window.
  - On an illegal address: go to HALT, fetch_err<=1, pc keeps its last legal value.
  - A target stored into tgt is checked when it is loaded into pc, not when it is stored.
- HALT: im_req=0, instr_valid=0, fetch_err=1. Redirects are ignored. Only reset exits HALT.
- Arithmetic: pc+4 is modulo 2^32. Any wrap falls outside the window, so it halts.

## Timing
- Reset deassertion: START for one cycle, im_req first high on the following cycle.
- im_ack at cycle N: instr_valid=1 with instr=im_rdata from cycle N+1.
- instr_ready at cycle N in VALID: next request (pc+4) issued at cycle N+1.
- Zero-wait memory (im_ack in the same cycle as im_req) gives a peak throughput of one instruction per 2 cycles.
- Redirect at cycle N, not in DROP and no ack pending: request to the target at cycle N+1.
- fetch_err rises the cycle after the offending edge and stays high.
- Reset asserted mid-transaction: everything clears immediately, and an outstanding ack is ignored after re-entry.

## Test plan
- Reset release with 2-cycle memory latency: im_req at cycle 1 with im_addr=0x3000. Ack at cycle 2 gives instr_valid at cycle 3. Ready at cycle 3 gives im_addr=0x3004 at cycle 4.
- Decode stalls (instr_ready=0 for 5 cycles): instr, pc and instr_valid stay stable and im_req=0. On ready, the next fetch is 0x3004.
- Redirect to 0x3100 while a request to 0x3008 is pending: im_addr stays 0x3008 until ack, that data never becomes valid, and the next request is 0x3100.
- Redirect to 0x3200 in the same cycle as instr_ready in VALID: the instruction is not counted and the next im_addr is 0x3200, not pc+4.
- Redirect to 0x3002 (misaligned), and separately to 0x4000 with default parameters: HALT, fetch_err=1 next cycle, im_req=0, pc unchanged. Later redirects have no effect.
- Reset asserted while in DROP: outputs return to reset values immediately. After release the fetch restarts at 0x3000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer.
// Owns the program counter, issues single-word requests to a multi-cycle
// instruction memory (req/ack), and hands each fetched word to decode over a
// valid/ready handshake. Redirects may arrive in any state; data belonging to
// a superseded request is dropped. An illegal fetch address halts the unit
// until reset, with a sticky error flag.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        instr_ready,
  output logic        fetch_err
);

  // Fetch window end, computed one bit wider so a window touching the top of
  // the address space does not wrap to zero.
  localparam logic [32:0] WIN_LO = {1'b0, RESET_PC};
  localparam logic [32:0] WIN_HI = {1'b0, RESET_PC} + (33'(IM_WORDS) << 2);

  typedef enum logic [2:0] {
    ST_START = 3'd0,  // one idle cycle after reset release
    ST_REQ   = 3'd1,  // request to pc outstanding
    ST_VALID = 3'd2,  // fetched word presented to decode
    ST_DROP  = 3'd3,  // request outstanding, its data is stale
    ST_HALT  = 3'd4   // illegal address seen, wait for reset
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;

  // A pc load requested by the FSM; the legality check is applied once, here,
  // no matter which transition asked for the load.
  logic        load_en;
  logic [31:0] load_addr;
  logic        load_legal;

  function automatic logic addr_legal(input logic [31:0] addr);
    logic [32:0] a;
    a = {1'b0, addr};
    return (addr[1:0] == 2'b00) && (a >= WIN_LO) && (a < WIN_HI);
  endfunction

  assign load_legal = addr_legal(load_addr);

  // State and datapath registers.
  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: instr is a plain data register but is still reset, so decode
      // never sees an undefined word out of reset; there is no array here
      // that would make resetting storage expensive.
      state_q <= ST_START;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-datapath logic.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    instr_d   = instr_q;
    err_d     = err_q;
    load_en   = 1'b0;
    load_addr = pc_q;

    unique case (state_q)
      ST_START: begin
        state_d = ST_REQ;
      end

      ST_REQ: begin
        if (redirect && im_ack) begin
          // Returned word belongs to the old flow; re-request at the target.
          load_en   = 1'b1;
          load_addr = redirect_pc;
        end else if (redirect) begin
          // Request must stay up until acked; park the target meanwhile.
          tgt_d   = redirect_pc;
          state_d = ST_DROP;
        end else if (im_ack) begin
          instr_d = im_rdata;
          state_d = ST_VALID;
        end
      end

      ST_DROP: begin
        if (redirect) begin
          tgt_d = redirect_pc;
        end
        if (im_ack) begin
          load_en   = 1'b1;
          load_addr = redirect ? redirect_pc : tgt_q;
        end
      end

      ST_VALID: begin
        if (redirect) begin
          // Redirect wins over ready: the presented word is discarded.
          load_en   = 1'b1;
          load_addr = redirect_pc;
        end else if (instr_ready) begin
          load_en   = 1'b1;
          load_addr = pc_q + 32'd4;
        end
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end
    endcase

    // Every new pc is screened at the edge it would be loaded; on failure pc
    // keeps its last legal value and the unit halts.
    if (load_en) begin
      if (load_legal) begin
        pc_d    = load_addr;
        state_d = ST_REQ;
      end else begin
        state_d = ST_HALT;
        err_d   = 1'b1;
      end
    end
  end

  // Output decode from the registered state only, so the memory and decode
  // interfaces see glitch-free, edge-aligned controls.
  always_comb begin
    im_req      = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      ST_REQ,
      ST_DROP:  im_req      = 1'b1;
      ST_VALID: instr_valid = 1'b1;
      default: begin
        im_req      = 1'b0;
        instr_valid = 1'b0;
      end
    endcase
  end

  assign im_addr   = pc_q;
  assign pc        = pc_q;
  assign instr     = instr_q;
  assign fetch_err = err_q;

  // Handshake contract toward the memory: a raised request is held, with a
  // stable address, until the cycle it is acknowledged.
  req_held_until_ack: assert property (
    @(posedge clk) disable iff (!reset)
      (im_req && !im_ack) |=> (im_req && $stable(im_addr))
  );

  // Halt is terminal and always flagged.
  halt_is_sticky: assert property (
    @(posedge clk) disable iff (!reset)
      fetch_err |=> (fetch_err && !im_req && !instr_valid)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. Inputs change 1 time unit after each
// rising edge; scenario tasks check outputs at that point, and a scoreboard
// monitor compares every instruction decode consumes on the falling edge.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_t;

  fetch_t sb[$];

  fetch_ctrl #(
    .RESET_PC (32'h0000_3000),
    .IM_WORDS (1024)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .instr_ready (instr_ready),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents as seen by the bench: an address-derived word.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return {~addr[15:0], addr[15:0]} ^ 32'h5A5A_0000;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    redirect    = 1'b0;
    redirect_pc = '0;
    im_ack      = 1'b0;
    im_rdata    = '0;
    instr_ready = 1'b0;
  endtask

  // Reset, then release it so the current cycle is the START cycle.
  task automatic do_reset();
    drive_idle();
    reset = 1'b0;
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  // Ack the pending request with data that will be thrown away later.
  task automatic ack_unscored();
    im_ack   = 1'b1;
    im_rdata = 32'hDEAD_BEEF;
    next_cycle();
    im_ack   = 1'b0;
  endtask

  // Scoreboard: every word decode takes (valid & ready, no redirect) must be
  // the next expected fetch.
  always @(negedge clk) begin
    if (reset && instr_valid && instr_ready && !redirect) begin
      fetch_t exp_f;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: consumed pc=%h instr=%h, none expected", pc, instr);
      end else begin
        exp_f = sb.pop_front();
        if (pc !== exp_f.pc || instr !== exp_f.instr) begin
          errors++;
          $display("FAIL sb_consume: got pc=%h instr=%h want pc=%h instr=%h",
                   pc, instr, exp_f.pc, exp_f.instr);
        end
      end
    end
  end

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    checks++;
    if (im_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctrl: got req=%b valid=%b err=%b want 0 0 0", im_req, instr_valid, fetch_err);
    end
    checks++;
    if (im_addr !== 32'h3000 || pc !== 32'h3000 || instr !== 32'h0) begin
      errors++;
      $display("FAIL rst_data: got addr=%h pc=%h instr=%h want 3000 3000 0", im_addr, pc, instr);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;                                  // cycle 0: START
    checks++;
    if (im_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_start_req: got %b want 0", im_req);
    end
    next_cycle();                                  // cycle 1
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3000) begin
      errors++;
      $display("FAIL rst_first_req: got req=%b addr=%h want 1 3000", im_req, im_addr);
    end
    next_cycle();                                  // cycle 2: memory answers
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3000 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_hold: got req=%b addr=%h valid=%b want 1 3000 0", im_req, im_addr, instr_valid);
    end
    im_ack   = 1'b1;
    im_rdata = mem_word(32'h3000);
    sb.push_back('{pc: 32'h3000, instr: mem_word(32'h3000)});
    next_cycle();                                  // cycle 3
    im_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== mem_word(32'h3000) || im_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got valid=%b instr=%h req=%b want 1 %h 0",
               instr_valid, instr, im_req, mem_word(32'h3000));
    end
    instr_ready = 1'b1;
    next_cycle();                                  // cycle 4
    instr_ready = 1'b0;
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3004) begin
      errors++;
      $display("FAIL rst_next_req: got req=%b addr=%h want 1 3004", im_req, im_addr);
    end
  endtask

  // In REQ at 0x3004; decode holds off for five cycles.
  task automatic test_stall();
    im_ack   = 1'b1;
    im_rdata = mem_word(32'h3004);
    sb.push_back('{pc: 32'h3004, instr: mem_word(32'h3004)});
    next_cycle();
    im_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== mem_word(32'h3004) || pc !== 32'h3004 || im_req !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h req=%b want 1 %h 3004 0",
                 i, instr_valid, instr, pc, im_req, mem_word(32'h3004));
      end
      next_cycle();
    end
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3008) begin
      errors++;
      $display("FAIL stall_next: got req=%b addr=%h want 1 3008", im_req, im_addr);
    end
  endtask

  // Request to 0x3008 pending; redirect to 0x3100 must wait out the ack.
  task automatic test_redirect_pending();
    redirect    = 1'b1;
    redirect_pc = 32'h3100;
    next_cycle();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (im_req !== 1'b1 || im_addr !== 32'h3008 || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL drop_hold[%0d]: got req=%b addr=%h valid=%b want 1 3008 0",
                 i, im_req, im_addr, instr_valid);
      end
      if (i == 0) next_cycle();
    end
    ack_unscored();
    checks++;
    if (instr_valid !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h3100) begin
      errors++;
      $display("FAIL drop_retarget: got valid=%b req=%b addr=%h want 0 1 3100", instr_valid, im_req, im_addr);
    end
    im_ack   = 1'b1;
    im_rdata = mem_word(32'h3100);
    sb.push_back('{pc: 32'h3100, instr: mem_word(32'h3100)});
    next_cycle();
    im_ack      = 1'b0;
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    checks++;
    if (im_addr !== 32'h3104) begin
      errors++;
      $display("FAIL drop_after: got addr=%h want 3104", im_addr);
    end
  endtask

  // In VALID, redirect and ready in the same cycle: redirect wins.
  task automatic test_redirect_with_ready();
    ack_unscored();                                // VALID with word for 0x3104
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h3200;
    next_cycle();
    instr_ready = 1'b0;
    redirect    = 1'b0;
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3200 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdy_redirect: got req=%b addr=%h valid=%b want 1 3200 0", im_req, im_addr, instr_valid);
    end
    im_ack   = 1'b1;
    im_rdata = mem_word(32'h3200);
    sb.push_back('{pc: 32'h3200, instr: mem_word(32'h3200)});
    next_cycle();
    im_ack      = 1'b0;
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
  endtask

  // In REQ at 0x3204, redirect coincides with the ack.
  task automatic test_redirect_with_ack();
    im_ack      = 1'b1;
    im_rdata    = 32'hBAD0_BAD0;
    redirect    = 1'b1;
    redirect_pc = 32'h3300;
    next_cycle();
    drive_idle();
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3300 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_redirect: got req=%b addr=%h valid=%b want 1 3300 0", im_req, im_addr, instr_valid);
    end
  endtask

  // Several redirects while a stale request is still outstanding.
  task automatic test_drop_retarget();
    redirect    = 1'b1;
    redirect_pc = 32'h3400;
    next_cycle();                                  // DROP, tgt=3400
    redirect_pc = 32'h3500;
    next_cycle();                                  // tgt=3500
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3300) begin
      errors++;
      $display("FAIL retgt_hold: got req=%b addr=%h want 1 3300", im_req, im_addr);
    end
    redirect_pc = 32'h3600;
    im_ack      = 1'b1;
    im_rdata    = 32'hBAD1_BAD1;
    next_cycle();
    drive_idle();
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3600 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL retgt_final: got req=%b addr=%h valid=%b want 1 3600 0", im_req, im_addr, instr_valid);
    end
    // Without a redirect at the ack, the last stored target is used.
    redirect    = 1'b1;
    redirect_pc = 32'h3700;
    next_cycle();
    redirect = 1'b0;
    ack_unscored();
    checks++;
    if (im_addr !== 32'h3700) begin
      errors++;
      $display("FAIL retgt_tgt: got addr=%h want 3700", im_addr);
    end
    im_ack   = 1'b1;
    im_rdata = mem_word(32'h3700);
    sb.push_back('{pc: 32'h3700, instr: mem_word(32'h3700)});
    next_cycle();
    im_ack      = 1'b0;
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
  endtask

  // Zero-wait memory and ready decode: one instruction every two cycles.
  task automatic test_back_to_back();
    logic [31:0] a;
    a = 32'h3704;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (im_req !== 1'b1 || im_addr !== a) begin
        errors++;
        $display("FAIL b2b_req[%0d]: got req=%b addr=%h want 1 %h", i, im_req, im_addr, a);
      end
      im_ack   = 1'b1;
      im_rdata = mem_word(a);
      sb.push_back('{pc: a, instr: mem_word(a)});
      next_cycle();
      im_ack      = 1'b0;
      instr_ready = 1'b1;
      next_cycle();
      instr_ready = 1'b0;
      a = a + 32'd4;
    end
  endtask

  // Last word of the window: sequential pc+4 = 0x4000 must halt.
  task automatic test_window_top();
    ack_unscored();
    redirect    = 1'b1;
    redirect_pc = 32'h3FFC;
    next_cycle();
    redirect = 1'b0;
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3FFC || fetch_err !== 1'b0) begin
      errors++;
      $display("FAIL top_req: got req=%b addr=%h err=%b want 1 3ffc 0", im_req, im_addr, fetch_err);
    end
    im_ack   = 1'b1;
    im_rdata = mem_word(32'h3FFC);
    sb.push_back('{pc: 32'h3FFC, instr: mem_word(32'h3FFC)});
    next_cycle();
    im_ack      = 1'b0;
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || im_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h3FFC) begin
      errors++;
      $display("FAIL top_halt: got err=%b req=%b valid=%b pc=%h want 1 0 0 3ffc",
               fetch_err, im_req, instr_valid, pc);
    end
  endtask

  // Misaligned redirect from VALID; later redirects and acks are ignored.
  task automatic test_halt_misaligned();
    do_reset();
    next_cycle();                                  // REQ 0x3000
    ack_unscored();                                // VALID
    checks++;
    if (fetch_err !== 1'b0 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL mis_pre: got err=%b valid=%b want 0 1", fetch_err, instr_valid);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h3002;
    next_cycle();
    redirect = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || im_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h3000) begin
      errors++;
      $display("FAIL mis_halt: got err=%b req=%b valid=%b pc=%h want 1 0 0 3000",
               fetch_err, im_req, instr_valid, pc);
    end
    for (int i = 0; i < 3; i++) begin
      redirect    = 1'b1;
      redirect_pc = 32'h3100;
      im_ack      = 1'b1;
      next_cycle();
      checks++;
      if (fetch_err !== 1'b1 || im_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h3000) begin
        errors++;
        $display("FAIL mis_ignore[%0d]: got err=%b req=%b valid=%b pc=%h want 1 0 0 3000",
                 i, fetch_err, im_req, instr_valid, pc);
      end
    end
    drive_idle();
  endtask

  // Out-of-window target parked in tgt is only rejected when loaded.
  task automatic test_halt_window();
    do_reset();
    next_cycle();                                  // REQ 0x3000
    redirect    = 1'b1;
    redirect_pc = 32'h4000;
    next_cycle();
    redirect = 1'b0;
    checks++;
    if (fetch_err !== 1'b0 || im_req !== 1'b1 || im_addr !== 32'h3000) begin
      errors++;
      $display("FAIL win_drop: got err=%b req=%b addr=%h want 0 1 3000", fetch_err, im_req, im_addr);
    end
    ack_unscored();
    checks++;
    if (fetch_err !== 1'b1 || im_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h3000) begin
      errors++;
      $display("FAIL win_halt: got err=%b req=%b valid=%b pc=%h want 1 0 0 3000",
               fetch_err, im_req, instr_valid, pc);
    end
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    next_cycle();
    redirect = 1'b0;
    checks++;
    if (fetch_err !== 1'b1 || im_req !== 1'b0) begin
      errors++;
      $display("FAIL win_ignore: got err=%b req=%b want 1 0", fetch_err, im_req);
    end
  endtask

  // Reset while a stale request is outstanding; a held ack is not taken.
  task automatic test_reset_in_drop();
    do_reset();
    next_cycle();                                  // REQ 0x3000
    redirect    = 1'b1;
    redirect_pc = 32'h3100;
    next_cycle();                                  // DROP
    redirect = 1'b0;
    #1;
    reset  = 1'b0;
    im_ack = 1'b1;
    im_rdata = 32'hBAD2_BAD2;
    #1;
    checks++;
    if (im_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 ||
        pc !== 32'h3000 || im_addr !== 32'h3000 || instr !== 32'h0) begin
      errors++;
      $display("FAIL drop_rst: got req=%b valid=%b err=%b pc=%h addr=%h instr=%h want 0 0 0 3000 3000 0",
               im_req, instr_valid, fetch_err, pc, im_addr, instr);
    end
    next_cycle();
    next_cycle();
    reset = 1'b1;                                  // START, ack still high
    next_cycle();                                  // REQ
    im_ack = 1'b0;
    checks++;
    if (im_req !== 1'b1 || im_addr !== 32'h3000 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL drop_rst_restart: got req=%b addr=%h valid=%b want 1 3000 0", im_req, im_addr, instr_valid);
    end
    next_cycle();
    im_ack   = 1'b1;
    im_rdata = mem_word(32'h3000);
    sb.push_back('{pc: 32'h3000, instr: mem_word(32'h3000)});
    next_cycle();
    im_ack      = 1'b0;
    instr_ready = 1'b1;
    next_cycle();
    instr_ready = 1'b0;
    checks++;
    if (im_addr !== 32'h3004) begin
      errors++;
      $display("FAIL drop_rst_next: got addr=%h want 3004", im_addr);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_pending();
    test_redirect_with_ready();
    test_redirect_with_ack();
    test_drop_retarget();
    test_back_to_back();
    test_window_top();
    test_halt_misaligned();
    test_halt_window();
    test_reset_in_drop();
    next_cycle();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d pending fetches want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
